// File: rtl/rf_wb_queue_if.sv
// Bus between write-back producers, the queue and the register-file write port.
interface rf_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic [AW-1:0] in_regsel;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          drain_en;
    logic [AW-1:0] writeregsel;
    logic [DW-1:0] writedata;
    logic          write;
    logic [AW-1:0] byp1sel;
    logic [AW-1:0] byp2sel;
    logic          byp1hit;
    logic          byp2hit;
    logic [DW-1:0] byp1data;
    logic [DW-1:0] byp2data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;

    modport slave (
        input  in_valid, in_regsel, in_data, drain_en, byp1sel, byp2sel,
        output in_ready, writeregsel, writedata, write,
               byp1hit, byp2hit, byp1data, byp2data, count, full, empty, err
    );

    modport master (
        output in_valid, in_regsel, in_data, drain_en, byp1sel, byp2sel,
        input  in_ready, writeregsel, writedata, write,
               byp1hit, byp2hit, byp1data, byp2data, count, full, empty, err
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Write-back queue: circular FIFO of pending register writes, a registered
// write stage toward the register file, and two newest-wins bypass lookups.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } byp_t;

    logic [AW-1:0] r_mem_sel  [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic          r_write;
    logic [AW-1:0] r_wsel;
    logic [DW-1:0] r_wdata;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_reject;
    byp_t          w_byp1;
    byp_t          w_byp2;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = bus.drain_en & ~w_empty;
    assign w_push   = bus.in_valid & (~w_full | w_pop);
    assign w_reject = bus.in_valid & w_full & ~w_pop;

    // FIFO storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_sel[i]  <= '0;
                r_mem_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_sel[r_wr_ptr]  <= bus.in_regsel;
                r_mem_data[r_wr_ptr] <= bus.in_data;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_reject) begin
                r_err <= 1'b1;
            end
        end
    end

    // Write stage: issue the head entry on pop, otherwise hold select/data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_wsel  <= '0;
            r_wdata <= '0;
        end else begin
            r_write <= w_pop;
            if (w_pop) begin
                r_wsel  <= r_mem_sel[r_rd_ptr];
                r_wdata <= r_mem_data[r_rd_ptr];
            end
        end
    end

    // Scans oldest-first and lets later matches overwrite, so the newest
    // pending write wins; the write stage is older than every FIFO entry.
    function automatic byp_t lookup(input logic [AW-1:0] sel);
        byp_t          res;
        logic [PW-1:0] idx;
        res = '0;
        if (r_write && (r_wsel == sel)) begin
            res.hit  = 1'b1;
            res.data = r_wdata;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if ((i < 32'(r_count)) && (r_mem_sel[idx] == sel)) begin
                res.hit  = 1'b1;
                res.data = r_mem_data[idx];
            end
        end
        return res;
    endfunction

    // Combinational bypass lookups for both read ports
    always_comb begin
        w_byp1 = lookup(bus.byp1sel);
        w_byp2 = lookup(bus.byp2sel);
    end

    assign bus.in_ready    = ~w_full | w_pop;
    assign bus.writeregsel = r_wsel;
    assign bus.writedata   = r_wdata;
    assign bus.write       = r_write;
    assign bus.byp1hit     = w_byp1.hit;
    assign bus.byp1data    = w_byp1.data;
    assign bus.byp2hit     = w_byp2.hit;
    assign bus.byp2data    = w_byp2.data;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: stimulus pushes expected register-file
// writes into a queue; a monitor pops and compares every issued write.
module tb_rf_wb_queue;
    logic clk;
    logic rst;

    rf_wb_queue_if #(.DEPTH(4), .DW(16), .AW(3)) bus ();

    rf_wb_queue #(.DEPTH(4), .DW(16), .AW(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [2:0] sel, input logic [15:0] data, input bit expect_written);
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_regsel = sel;
        bus.in_data   = data;
        if (expect_written) begin
            e.sel  = sel;
            e.data = data;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        check("sb_empty_before_reset", 32'(sb.size()), 0);
        rst = 1'b0;
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_write", 32'(bus.write), 0);
        check("rst_err", 32'(bus.err), 0);
        rst = 1'b1;
    endtask

    // Monitor: every cycle the write strobe is high is one register-file write
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.write === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual sel=%0d data=0x%0h required none",
                         bus.writeregsel, bus.writedata);
            end else begin
                e = sb.pop_front();
                check("wr_sel", 32'(bus.writeregsel), 32'(e.sel));
                check("wr_data", 32'(bus.writedata), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_regsel = 3'd3;
        bus.in_data   = 16'h5555;
        bus.drain_en  = 1'b1;
        bus.byp1sel   = 3'd3;
        bus.byp2sel   = 3'd0;

        // Reset held with push attempted
        repeat (3) tick();
        check("rst_write", 32'(bus.write), 0);
        check("rst_wsel", 32'(bus.writeregsel), 0);
        check("rst_wdata", 32'(bus.writedata), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_err", 32'(bus.err), 0);
        check("rst_byp1hit", 32'(bus.byp1hit), 0);
        check("rst_byp1data", 32'(bus.byp1data), 0);
        check("rst_byp2hit", 32'(bus.byp2hit), 0);

        // First transaction latency
        rst = 1'b1;
        set_push(3'd3, 16'h1234, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("lat_count_e1", 32'(bus.count), 1);
        check("lat_write_e1", 32'(bus.write), 0);
        tick();
        check("lat_write_e2", 32'(bus.write), 1);
        check("lat_wsel_e2", 32'(bus.writeregsel), 3);
        check("lat_wdata_e2", 32'(bus.writedata), 32'h1234);
        check("lat_count_e2", 32'(bus.count), 0);
        tick();
        check("lat_write_e3", 32'(bus.write), 0);
        check("lat_wdata_hold", 32'(bus.writedata), 32'h1234);

        // Fill and overflow
        bus.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(3'(i), 16'hA000 + 16'(i), 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("fill_full", 32'(bus.full), 1);
        check("fill_in_ready", 32'(bus.in_ready), 0);
        check("fill_count", 32'(bus.count), 4);
        check("fill_err", 32'(bus.err), 0);
        set_push(3'd4, 16'hBEEF, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("ovf_err", 32'(bus.err), 1);
        check("ovf_count", 32'(bus.count), 4);
        bus.drain_en = 1'b1;
        repeat (5) tick();
        check("ovf_drained", 32'(bus.count), 0);
        check("ovf_err_sticky", 32'(bus.err), 1);
        bus.drain_en = 1'b0;
        do_reset();

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) begin
            set_push(3'(i), 16'hC000 + 16'(i), 1'b1);
            tick();
        end
        bus.drain_en = 1'b1;
        set_push(3'd5, 16'h5555, 1'b1);
        #1;
        check("pp_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("pp_count", 32'(bus.count), 4);
        check("pp_err", 32'(bus.err), 0);
        repeat (6) tick();
        check("pp_drained", 32'(bus.count), 0);
        bus.drain_en = 1'b0;

        // Bypass newest-wins
        set_push(3'd2, 16'h0001, 1'b1);
        tick();
        set_push(3'd6, 16'h0600, 1'b1);
        tick();
        set_push(3'd2, 16'h0002, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.byp1sel  = 3'd2;
        bus.byp2sel  = 3'd6;
        #1;
        check("byp1_hit_r2", 32'(bus.byp1hit), 1);
        check("byp1_data_r2", 32'(bus.byp1data), 32'h0002);
        check("byp2_hit_r6", 32'(bus.byp2hit), 1);
        check("byp2_data_r6", 32'(bus.byp2data), 32'h0600);
        bus.byp2sel = 3'd7;
        #1;
        check("byp2_hit_r7", 32'(bus.byp2hit), 0);
        check("byp2_data_r7", 32'(bus.byp2data), 0);
        bus.drain_en = 1'b1;
        repeat (4) tick();
        bus.drain_en = 1'b0;

        // Bypass through the write stage
        bus.drain_en = 1'b1;
        bus.byp1sel  = 3'd1;
        set_push(3'd1, 16'h00FF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("ws_fifo_hit", 32'(bus.byp1hit), 1);
        tick();
        check("ws_write", 32'(bus.write), 1);
        check("ws_hit", 32'(bus.byp1hit), 1);
        check("ws_data", 32'(bus.byp1data), 32'h00FF);
        tick();
        check("ws_after_hit", 32'(bus.byp1hit), 0);
        check("ws_after_data", 32'(bus.byp1data), 0);
        bus.drain_en = 1'b0;

        // Pointer wrap with drain toggling every cycle
        for (int i = 0; i < 10; i++) begin
            bus.drain_en = 1'b1;
            set_push(3'(i % 8), 16'hD000 + 16'(i), 1'b1);
            tick();
            check("wrap_cnt_le", 32'(bus.count <= 4), 1);
            bus.in_valid = 1'b0;
            bus.drain_en = 1'b0;
            tick();
            check("wrap_cnt_le", 32'(bus.count <= 4), 1);
        end
        bus.drain_en = 1'b1;
        repeat (3) tick();
        check("wrap_err", 32'(bus.err), 0);
        check("wrap_empty", 32'(bus.empty), 1);
        check("sb_empty_end", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
